// File: rtl/rv_hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// rv_hazard_scoreboard_if
//   Bundle between the ID stage (master) and the hazard scoreboard (slave).
//   Master drives the decoded ID instruction, the EX flush and the
//   multi-cycle unit completion. The slave returns the stall / write-enable
//   controls and the pending-register debug view.
//
//   id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used   ID source operands
//   id_rd, id_RegWEn, id_lat, id_mc                      ID destination info
//   flush                                                kill instr in ID
//   mc_done, mc_rd                                       MC unit completion
//   stall, PCWrite, IF_ID_Write, id_bubble, issue        pipeline controls
//   mc_busy, pending                                     status / debug
// ----------------------------------------------------------------------------
interface rv_hazard_scoreboard_if #(
    parameter int NREG   = 32,
    parameter int ADDR_W = $clog2(NREG),
    parameter int CNT_W  = 3
);
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [ADDR_W-1:0] id_rd;
    logic              id_RegWEn;
    logic [CNT_W-1:0]  id_lat;
    logic              id_mc;
    logic              flush;
    logic              mc_done;
    logic [ADDR_W-1:0] mc_rd;

    logic              stall;
    logic              PCWrite;
    logic              IF_ID_Write;
    logic              id_bubble;
    logic              issue;
    logic              mc_busy;
    logic [NREG-1:0]   pending;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_RegWEn, id_lat, id_mc, flush, mc_done, mc_rd,
        input  stall, PCWrite, IF_ID_Write, id_bubble, issue, mc_busy, pending
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_RegWEn, id_lat, id_mc, flush, mc_done, mc_rd,
        output stall, PCWrite, IF_ID_Write, id_bubble, issue, mc_busy, pending
    );
endinterface

// File: rtl/rv_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// rv_hazard_scoreboard
//   ID-stage hazard controller for the 5-stage RV32 pipeline. Each
//   architectural register (except x0) has a countdown of cycles until its
//   pending result becomes forwardable; the all-ones code MC means "waiting
//   for the multi-cycle unit". One multi-cycle op (DIV/REM) may be
//   outstanding; its completion (mc_done/mc_rd) arrives independently of
//   issue and releases dependents in the same cycle.
//
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   sb         : rv_hazard_scoreboard_if.slave (ID inputs, pipeline controls)
// ----------------------------------------------------------------------------
module rv_hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int ADDR_W = $clog2(NREG),
    parameter int CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rv_hazard_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] MC      = '1;
    localparam logic [CNT_W-1:0] LAT_MAX = MC - CNT_W'(1);

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic             mc_busy_q;

    logic             rs1_release, rs2_release;
    logic             hz1, hz2, hzmc;
    logic             stall, issue, wr_en;
    logic [CNT_W-1:0] lat_fin;

    // A completing multi-cycle op releases its destination in the same
    // cycle, so a dependent sitting in ID does not pay an extra stall.
    assign rs1_release = sb.mc_done && (sb.mc_rd == sb.id_rs1) && (cnt[sb.id_rs1] == MC);
    assign rs2_release = sb.mc_done && (sb.mc_rd == sb.id_rs2) && (cnt[sb.id_rs2] == MC);

    assign hz1  = sb.id_rs1_used && (sb.id_rs1 != '0) && (cnt[sb.id_rs1] != '0) && !rs1_release;
    assign hz2  = sb.id_rs2_used && (sb.id_rs2 != '0) && (cnt[sb.id_rs2] != '0) && !rs2_release;
    assign hzmc = sb.id_mc && mc_busy_q && !sb.mc_done;

    // A flushed instruction is dead, so it never waits on anything.
    assign stall = sb.id_valid && !sb.flush && (hz1 || hz2 || hzmc);
    assign issue = sb.id_valid && !stall && !sb.flush;
    assign wr_en = issue && sb.id_RegWEn && (sb.id_rd != '0);

    // The MC code is reserved; a finite latency saturates just below it.
    assign lat_fin = (sb.id_lat == MC) ? LAT_MAX : sb.id_lat;

    assign sb.stall       = stall;
    assign sb.issue       = issue;
    assign sb.PCWrite     = !stall;
    assign sb.IF_ID_Write = !stall;
    assign sb.id_bubble   = stall || sb.flush || !sb.id_valid;
    assign sb.mc_busy     = mc_busy_q;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            sb.pending[r] = (cnt[r] != '0);
        end
    end

    // Next countdown per register. Later assignments win, giving the
    // priority issue write > mc_done clear > decrement.
    // NOTE: every always_comb target gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
            if (cnt[r] != '0 && cnt[r] != MC) begin
                cnt_nxt[r] = cnt[r] - CNT_W'(1);
            end
            if (sb.mc_done && sb.mc_rd == ADDR_W'(r) && cnt[r] == MC) begin
                cnt_nxt[r] = '0;
            end
            // WAW: keep whichever wait is longer (an older MC wait survives).
            if (wr_en && sb.id_rd == ADDR_W'(r)) begin
                if (sb.id_mc) begin
                    cnt_nxt[r] = MC;
                end else if (lat_fin > cnt_nxt[r]) begin
                    cnt_nxt[r] = lat_fin;
                end
            end
            if (r == 0) begin
                cnt_nxt[r] = '0;
            end
        end
    end

    // NOTE: the countdown array is reset like any other state because a reset
    // must discard every pending write; it is small flop storage, not RAM.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            mc_busy_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            // A new MC issue in the completion cycle keeps the unit busy.
            if (issue && sb.id_mc) begin
                mc_busy_q <= 1'b1;
            end else if (sb.mc_done) begin
                mc_busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rv_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_rv_hazard_scoreboard
//   Directed scenarios with literal expectations, then randomized traffic.
//   The reference model tracks, per register, the absolute cycle at which its
//   value becomes forwardable (or an "awaiting MC completion" flag) and
//   derives every output from that each cycle.
// ----------------------------------------------------------------------------
module tb_rv_hazard_scoreboard;
    localparam int NREG   = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_hazard_scoreboard_if #(.NREG(NREG), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) sb ();

    rv_hazard_scoreboard #(.NREG(NREG), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb)
    );

    typedef struct {
        logic              valid;
        logic [ADDR_W-1:0] rs1;
        logic              rs1_used;
        logic [ADDR_W-1:0] rs2;
        logic              rs2_used;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic [CNT_W-1:0]  lat;
        logic              mc;
        logic              flush;
        logic              mc_done;
        logic [ADDR_W-1:0] mc_rd;
    } stim_t;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int ready   [NREG];   // first cycle at which register is forwardable
    bit waiting [NREG];   // awaiting multi-cycle completion
    bit m_busy;
    int m_mc_rd;
    int now;
    bit e_issue;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            ready[r]   = 0;
            waiting[r] = 1'b0;
        end
        m_busy  = 1'b0;
        m_mc_rd = 0;
        now     = 0;
    endtask

    function automatic bit busy_now(input int r);
        if (r == 0) return 1'b0;
        if (waiting[r]) return !(sb.mc_done && int'(sb.mc_rd) == r);
        return now < ready[r];
    endfunction

    task automatic compare();
        bit hz1, hz2, hzmc, e_stall;
        logic [NREG-1:0] e_pend;
        hz1     = sb.id_rs1_used && busy_now(int'(sb.id_rs1));
        hz2     = sb.id_rs2_used && busy_now(int'(sb.id_rs2));
        hzmc    = sb.id_mc && m_busy && !sb.mc_done;
        e_stall = sb.id_valid && !sb.flush && (hz1 || hz2 || hzmc);
        e_issue = sb.id_valid && !e_stall && !sb.flush;
        for (int r = 0; r < NREG; r++) e_pend[r] = (r != 0) && (waiting[r] || now < ready[r]);
        check("stall",       32'(sb.stall),       32'(e_stall));
        check("PCWrite",     32'(sb.PCWrite),     32'(!e_stall));
        check("IF_ID_Write", 32'(sb.IF_ID_Write), 32'(!e_stall));
        check("id_bubble",   32'(sb.id_bubble),   32'(e_stall || sb.flush || !sb.id_valid));
        check("issue",       32'(sb.issue),       32'(e_issue));
        check("mc_busy",     32'(sb.mc_busy),     32'(m_busy));
        check("pending",     32'(sb.pending),     32'(e_pend));
    endtask

    task automatic model_update();
        int rd;
        rd = int'(sb.id_rd);
        if (sb.mc_done) begin
            if (waiting[int'(sb.mc_rd)]) begin
                waiting[int'(sb.mc_rd)] = 1'b0;
                ready[int'(sb.mc_rd)]   = now;
            end
            m_busy = 1'b0;
        end
        if (e_issue && sb.id_mc) begin
            m_busy  = 1'b1;
            m_mc_rd = rd;
        end
        if (e_issue && sb.id_RegWEn && rd != 0) begin
            if (sb.id_mc) begin
                waiting[rd] = 1'b1;
            end else if (!waiting[rd] && now + 1 + int'(sb.id_lat) > ready[rd]) begin
                ready[rd] = now + 1 + int'(sb.id_lat);
            end
        end
        now++;
    endtask

    task automatic drive(input stim_t s);
        sb.id_valid    = s.valid;
        sb.id_rs1      = s.rs1;
        sb.id_rs1_used = s.rs1_used;
        sb.id_rs2      = s.rs2;
        sb.id_rs2_used = s.rs2_used;
        sb.id_rd       = s.rd;
        sb.id_RegWEn   = s.we;
        sb.id_lat      = s.lat;
        sb.id_mc       = s.mc;
        sb.flush       = s.flush;
        sb.mc_done     = s.mc_done;
        sb.mc_rd       = s.mc_rd;
    endtask

    // Drive inputs, then check against the model on the falling edge.
    task automatic apply(input stim_t s);
        drive(s);
        @(negedge clk);
        compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{valid: 1'b0, rs1: '0, rs1_used: 1'b0, rs2: '0, rs2_used: 1'b0, rd: '0,
              we: 1'b0, lat: '0, mc: 1'b0, flush: 1'b0, mc_done: 1'b0, mc_rd: '0};
        return s;
    endfunction

    // Instruction writing rd (if nonzero we) reading rs1.
    function automatic stim_t instr(input int rd, input int lat, input bit mc, input int rs1);
        stim_t s;
        s          = idle();
        s.valid    = 1'b1;
        s.rd       = ADDR_W'(rd);
        s.we       = 1'b1;
        s.lat      = CNT_W'(lat);
        s.mc       = mc;
        s.rs1      = ADDR_W'(rs1);
        s.rs1_used = (rs1 != 0);
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s          = idle();
        s.valid    = ($urandom_range(9) < 8);
        s.rs1      = ADDR_W'(($urandom_range(3) == 0) ? $urandom_range(31) : $urandom_range(7));
        s.rs2      = ADDR_W'(($urandom_range(3) == 0) ? $urandom_range(31) : $urandom_range(7));
        s.rs1_used = $urandom_range(1) == 1;
        s.rs2_used = $urandom_range(1) == 1;
        s.rd       = ADDR_W'($urandom_range(7));
        s.we       = $urandom_range(3) != 0;
        s.lat      = CNT_W'($urandom_range(6));
        s.mc       = ($urandom_range(9) == 0);
        if (s.mc) begin
            s.we = 1'b1;
            s.rd = ADDR_W'($urandom_range(7, 1));
        end
        s.flush = ($urandom_range(9) == 0);
        if (m_busy && $urandom_range(3) == 0) begin
            s.mc_done = 1'b1;
            s.mc_rd   = ADDR_W'(m_mc_rd);
        end
        return s;
    endfunction

    initial begin
        stim_t s;

        // Reset state: issue follows id_valid & ~flush even in reset.
        model_reset();
        s       = idle();
        s.valid = 1'b1;
        drive(s);
        #3;
        check("rst_stall",   32'(sb.stall),   32'd0);
        check("rst_PCWrite", 32'(sb.PCWrite), 32'd1);
        check("rst_pending", 32'(sb.pending), 32'd0);
        check("rst_mc_busy", 32'(sb.mc_busy), 32'd0);
        check("rst_issue",   32'(sb.issue),   32'd1);
        drive(idle());
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: ALU producer, dependent issues back-to-back.
        apply(instr(5, 0, 0, 0));
        check("t1_issue_a", 32'(sb.issue), 32'd1);
        advance();
        apply(instr(6, 0, 0, 5));
        check("t1_stall_b", 32'(sb.stall), 32'd0);
        check("t1_issue_b", 32'(sb.issue), 32'd1);
        advance();

        // 2: load-use, one stall cycle.
        apply(instr(5, 1, 0, 0));
        advance();
        apply(instr(6, 0, 0, 5));
        check("t2_stall",   32'(sb.stall),     32'd1);
        check("t2_pcwrite", 32'(sb.PCWrite),   32'd0);
        check("t2_bubble",  32'(sb.id_bubble), 32'd1);
        advance();
        apply(instr(6, 0, 0, 5));
        check("t2_issue", 32'(sb.issue), 32'd1);
        advance();

        // 5: flush kills a dependent that would have stalled.
        apply(instr(5, 1, 0, 0));
        advance();
        s       = instr(6, 0, 0, 5);
        s.flush = 1'b1;
        apply(s);
        check("t5_stall",  32'(sb.stall),      32'd0);
        check("t5_issue",  32'(sb.issue),      32'd0);
        check("t5_bubble", 32'(sb.id_bubble),  32'd1);
        check("t5_pend5",  32'(sb.pending[5]), 32'd1);
        advance();
        apply(idle());
        check("t5_pend5_clr", 32'(sb.pending[5]), 32'd0);
        advance();

        // 3: div then dependent, released on mc_done.
        apply(instr(7, 0, 1, 0));
        advance();
        for (int i = 0; i < 3; i++) begin
            apply(instr(8, 0, 0, 7));
            check("t3_stall_hold", 32'(sb.stall), 32'd1);
            advance();
        end
        s         = instr(8, 0, 0, 7);
        s.mc_done = 1'b1;
        s.mc_rd   = ADDR_W'(7);
        apply(s);
        check("t3_issue",   32'(sb.issue),   32'd1);
        check("t3_busy_on", 32'(sb.mc_busy), 32'd1);
        advance();
        apply(idle());
        check("t3_busy_off", 32'(sb.mc_busy), 32'd0);
        advance();

        // 4: second div waits for the unit, issues in the completion cycle.
        apply(instr(7, 0, 1, 0));
        advance();
        for (int i = 0; i < 2; i++) begin
            apply(instr(9, 0, 1, 0));
            check("t4_stall", 32'(sb.stall), 32'd1);
            advance();
        end
        s         = instr(9, 0, 1, 0);
        s.mc_done = 1'b1;
        s.mc_rd   = ADDR_W'(7);
        apply(s);
        check("t4_issue", 32'(sb.issue), 32'd1);
        advance();
        apply(idle());
        check("t4_busy",  32'(sb.mc_busy),    32'd1);
        check("t4_pend9", 32'(sb.pending[9]), 32'd1);
        check("t4_pend7", 32'(sb.pending[7]), 32'd0);
        advance();
        s         = idle();
        s.mc_done = 1'b1;
        s.mc_rd   = ADDR_W'(9);
        apply(s);
        advance();

        // 6: reset mid-op clears everything immediately.
        apply(instr(7, 0, 1, 0));
        advance();
        rst_n = 1'b0;
        #1;
        check("t6_pending", 32'(sb.pending), 32'd0);
        check("t6_busy",    32'(sb.mc_busy), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        apply(instr(8, 0, 0, 7));
        check("t6_stall", 32'(sb.stall), 32'd0);
        check("t6_issue", 32'(sb.issue), 32'd1);
        advance();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            apply(rand_stim());
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
